rbe_tcdm_responder: RTL and testbench

- TCDM-side responder (slave) for the RBE streamer's wide master port. Accepts BW-bit load/store requests, stores data in an internal BW-wide word array, and returns read data through a buffered response channel.
- Used as a memory end-point in block-level benches and as a local scratch buffer behind the streamer's TCDM FIFO.
- Generates grant backpressure from response-buffer credits, so no read response is ever dropped.

---
 rtl/rbe_tcdm_responder.sv | 150 +++++++++++++++
 tb/tb_rbe_tcdm_responder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rbe_tcdm_responder.sv
// TCDM responder: BW-wide word array, LATENCY-deep read pipe, credit-gated response FIFO.
// Optional macro RBE_TCDM_RESP_STALL_EN adds stall_period_i, which forces a periodic no-grant cycle.
module rbe_tcdm_responder #(
   parameter int unsigned TP         = 32,
   parameter int unsigned MP         = 4,
   parameter int unsigned AW         = 32,
   parameter int unsigned NB_WORDS   = 1024,
   parameter int unsigned LATENCY    = 1,
   parameter int unsigned RESP_DEPTH = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                clear_i,
   input  logic                enable_i,
`ifdef RBE_TCDM_RESP_STALL_EN
   input  logic [7:0]          stall_period_i,
`endif
   input  logic                tcdm_req_i,
   output logic                tcdm_gnt_o,
   input  logic [AW-1:0]       tcdm_add_i,
   input  logic                tcdm_wen_i,
   input  logic [TP*MP/8-1:0]  tcdm_be_i,
   input  logic [TP*MP-1:0]    tcdm_data_i,
   output logic [TP*MP-1:0]    tcdm_r_data_o,
   output logic                tcdm_r_valid_o,
   input  logic                tcdm_r_ready_i,
   output logic [31:0]         rd_cnt_o,
   output logic [31:0]         wr_cnt_o,
   output logic                busy_o
);
   localparam int unsigned BW   = TP * MP;
   localparam int unsigned BEW  = BW / 8;
   localparam int unsigned OFFW = $clog2(BEW);
   localparam int unsigned IW   = $clog2(NB_WORDS);
   localparam int unsigned PW   = $clog2(RESP_DEPTH);
   localparam int unsigned CW   = $clog2(RESP_DEPTH + 1);
   localparam int unsigned IFW  = $clog2(RESP_DEPTH + LATENCY + 1);

   logic [BW-1:0]  r_mem [NB_WORDS];
   logic [BW-1:0]  r_fifo [RESP_DEPTH];
   logic [PW-1:0]  r_wptr, r_rptr;
   logic [CW-1:0]  r_cnt;
   logic [31:0]    r_rd_cnt, r_wr_cnt;

   logic [IW-1:0]  w_idx;
   logic           w_stall, w_rd_xfer, w_wr_xfer, w_push, w_pop, w_unused;
   logic [BW-1:0]  w_push_data;
   logic [IFW-1:0] w_pcnt, w_inflight;
   logic [LATENCY-1:0]         w_rv;
   logic [LATENCY-1:0][BW-1:0] w_rd;

   // Only aligned word indexing; offset and upper bits are dropped so addresses wrap.
   assign w_idx    = tcdm_add_i[OFFW +: IW];
   assign w_unused = ^{tcdm_add_i[AW-1:OFFW+IW], tcdm_add_i[OFFW-1:0]};

`ifdef RBE_TCDM_RESP_STALL_EN
   logic [7:0] r_stall_cnt;
   assign w_stall = (stall_period_i != 8'd0) && (r_stall_cnt == stall_period_i - 8'd1);
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                r_stall_cnt <= 8'd0;
      else if (clear_i || w_stall) r_stall_cnt <= 8'd0;
      else                        r_stall_cnt <= r_stall_cnt + 8'd1;
   end
`else
   assign w_stall = 1'b0;
`endif

   always_comb begin
      w_pcnt = '0;
      for (int i = 0; i < LATENCY; i++) w_pcnt = w_pcnt + IFW'(w_rv[i]);
   end
   assign w_inflight = w_pcnt + IFW'(r_cnt);

   assign tcdm_gnt_o = tcdm_req_i & enable_i & ~clear_i & ~w_stall &
                       (~tcdm_wen_i | (w_inflight < IFW'(RESP_DEPTH)));
   assign w_rd_xfer  = tcdm_gnt_o &  tcdm_wen_i;
   assign w_wr_xfer  = tcdm_gnt_o & ~tcdm_wen_i;

   always_ff @(posedge clk_i) begin
      if (w_wr_xfer)
         for (int b = 0; b < BEW; b++)
            if (tcdm_be_i[b]) r_mem[w_idx][b*8 +: 8] <= tcdm_data_i[b*8 +: 8];
   end

   // Stage 0 is the combinational array read at the grant edge; stages 1.. are registered.
   assign w_rv[0] = 1'b0;
   assign w_rd[0] = r_mem[w_idx];
   for (genvar g = 1; g < LATENCY; g++) begin : g_pipe
      logic          r_v;
      logic [BW-1:0] r_d;
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            r_v <= 1'b0;
            r_d <= '0;
         end else if (clear_i) begin
            r_v <= 1'b0;
         end else begin
            r_v <= (g == 1) ? w_rd_xfer : w_rv[g-1];
            r_d <= w_rd[g-1];
         end
      end
      assign w_rv[g] = r_v;
      assign w_rd[g] = r_d;
   end

   assign w_push      = (LATENCY == 1) ? w_rd_xfer : w_rv[LATENCY-1];
   assign w_push_data = w_rd[LATENCY-1];
   assign w_pop       = tcdm_r_valid_o & tcdm_r_ready_i;

   function automatic logic [PW-1:0] f_nxt(input logic [PW-1:0] p);
      return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk_i) begin
      if (w_push) r_fifo[r_wptr] <= w_push_data;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_cnt    <= '0;
         r_rd_cnt <= '0;
         r_wr_cnt <= '0;
      end else if (clear_i) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_cnt    <= '0;
         r_rd_cnt <= '0;
         r_wr_cnt <= '0;
      end else begin
         if (w_push) r_wptr <= f_nxt(r_wptr);
         if (w_pop)  r_rptr <= f_nxt(r_rptr);
         r_cnt    <= r_cnt + CW'(w_push) - CW'(w_pop);
         r_rd_cnt <= r_rd_cnt + 32'(w_rd_xfer);
         r_wr_cnt <= r_wr_cnt + 32'(w_wr_xfer);
      end
   end

   assign tcdm_r_valid_o = (r_cnt != '0);
   assign tcdm_r_data_o  = tcdm_r_valid_o ? r_fifo[r_rptr] : '0;
   assign rd_cnt_o       = r_rd_cnt;
   assign wr_cnt_o       = r_wr_cnt;
   assign busy_o         = (|w_rv) | tcdm_r_valid_o;

   // Credits guarantee a free slot for every read that reaches the FIFO.
   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni || clear_i)
      !(w_push && !w_pop && r_cnt == CW'(RESP_DEPTH)));

endmodule

// File: tb/tb_rbe_tcdm_responder.sv
// Scoreboard bench for rbe_tcdm_responder (default parameters, LATENCY=1, RESP_DEPTH=4).
module tb_rbe_tcdm_responder;
   localparam int BW  = 128;
   localparam int BEW = 16;
   localparam int NBW = 1024;

   logic            clk = 1'b0;
   logic            rst_n, clear, enable, req, gnt, wen, r_valid, r_ready, busy;
   logic [31:0]     add, rd_cnt, wr_cnt;
   logic [BEW-1:0]  be;
   logic [BW-1:0]   wdata, r_data;
`ifdef RBE_TCDM_RESP_STALL_EN
   logic [7:0]      stall_period;
`endif

   logic [BW-1:0]   ref_mem [NBW];
   logic [BW-1:0]   exp_q [$];
   logic [BW-1:0]   exp;
   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   rbe_tcdm_responder dut (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .enable_i(enable),
`ifdef RBE_TCDM_RESP_STALL_EN
      .stall_period_i(stall_period),
`endif
      .tcdm_req_i(req), .tcdm_gnt_o(gnt), .tcdm_add_i(add), .tcdm_wen_i(wen),
      .tcdm_be_i(be), .tcdm_data_i(wdata), .tcdm_r_data_o(r_data),
      .tcdm_r_valid_o(r_valid), .tcdm_r_ready_i(r_ready),
      .rd_cnt_o(rd_cnt), .wr_cnt_o(wr_cnt), .busy_o(busy)
   );

   task automatic issue(input logic rd, input int word, input logic [BW-1:0] d,
                        input logic [BEW-1:0] b);
      req = 1'b1; wen = rd; add = 32'(word) * 32'(BEW); wdata = d; be = b;
      #1;
   endtask

   task automatic idle();
      req = 1'b0; #1;
   endtask

   // Updates the reference model / scoreboard for this cycle's transfer, then advances one cycle.
   task automatic tick();
      int w;
      w = int'(add[4 +: 10]);
      if (clear) exp_q.delete();
      else if (req && gnt) begin
         if (wen) exp_q.push_back(ref_mem[w]);
         else for (int b = 0; b < BEW; b++) if (be[b]) ref_mem[w][b*8 +: 8] = wdata[b*8 +: 8];
      end
      @(posedge clk); @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; #3;
      checks++; if (gnt !== 1'b0) begin failures++; $display("FAIL reset_gnt got=%b want=0", gnt); end
      checks++; if (r_valid !== 1'b0 || r_data !== '0) begin failures++; $display("FAIL reset_resp got=%b/%h want=0/0", r_valid, r_data); end
      checks++; if (rd_cnt !== 0 || wr_cnt !== 0 || busy !== 1'b0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d/%b want=0/0/0", rd_cnt, wr_cnt, busy); end
      @(negedge clk); rst_n = 1'b1; @(negedge clk);
   endtask

   task automatic test_write_read();
      logic [BW-1:0] pat;
      pat = {16{8'hA5}};
      issue(1'b0, 3, pat, '1);
      checks++; if (gnt !== 1'b1) begin failures++; $display("FAIL wr_gnt got=%b want=1", gnt); end
      tick();
      issue(1'b1, 3, '0, '0);
      checks++; if (gnt !== 1'b1 || r_valid !== 1'b0) begin failures++; $display("FAIL rd_gnt got=%b/%b want=1/0", gnt, r_valid); end
      tick(); idle();
      checks++;
      if (r_valid !== 1'b1) begin failures++; $display("FAIL rd_latency r_valid=%b want=1", r_valid); end
      else begin
         exp = exp_q.pop_front();
         if (r_data !== pat || exp !== pat) begin failures++; $display("FAIL rd_data got=%h want=%h", r_data, pat); end
      end
      checks++; if (wr_cnt !== 1 || rd_cnt !== 1) begin failures++; $display("FAIL cnt_1 got=%0d/%0d want=1/1", wr_cnt, rd_cnt); end
      tick();
      checks++; if (r_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL drained got=%b/%b want=0/0", r_valid, busy); end
   endtask

   task automatic test_byte_enable();
      logic [BW-1:0] want;
      want = {{12{8'hFF}}, 32'h0};
      issue(1'b0, 5, '1, '1); tick();
      issue(1'b0, 5, '0, 16'h000F); tick();
      issue(1'b1, 5, '0, '0); tick(); idle();
      checks++;
      if (r_valid !== 1'b1 || exp_q.size() == 0) begin failures++; $display("FAIL be_valid r_valid=%b want=1", r_valid); end
      else begin
         exp = exp_q.pop_front();
         if (r_data !== want || r_data !== exp) begin failures++; $display("FAIL be_data got=%h want=%h", r_data, want); end
      end
      tick();
   endtask

   task automatic test_backpressure();
      int grants = 0, nxt, resp = 0, cyc = 0;
      for (int i = 0; i < 8; i++) begin
         issue(1'b0, i, {$urandom, $urandom, $urandom, $urandom}, '1); tick();
      end
      r_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         issue(1'b1, grants, '0, '0);
         checks++; if (gnt !== (grants < 4)) begin failures++; $display("FAIL bp_gnt%0d got=%b want=%b", k, gnt, grants < 4); end
         if (gnt) grants++;
         tick();
      end
      issue(1'b0, 9, {4{32'h1234_5678}}, '1);
      checks++; if (gnt !== 1'b1) begin failures++; $display("FAIL bp_wr_gnt got=%b want=1", gnt); end
      tick();
      issue(1'b1, 4, '0, '0);
      checks++; if (gnt !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL bp_full got=%b/%b want=0/1", gnt, busy); end
      r_ready = 1'b1;
      nxt = grants;
      while ((nxt < 8 || resp < 8) && cyc < 60) begin
         if (r_valid) begin
            checks++;
            if (exp_q.size() == 0) begin failures++; $display("FAIL bp_extra got=%h want=none", r_data); end
            else begin
               exp = exp_q.pop_front();
               if (r_data !== exp) begin failures++; $display("FAIL bp_order%0d got=%h want=%h", resp, r_data, exp); end
            end
            resp++;
         end
         if (nxt < 8) issue(1'b1, nxt, '0, '0); else idle();
         if (req && gnt) nxt++;
         tick(); cyc++;
      end
      idle();
      checks++; if (resp != 8 || nxt != 8) begin failures++; $display("FAIL bp_total got=%0d/%0d want=8/8", resp, nxt); end
   endtask

   task automatic test_wrap();
      issue(1'b1, NBW + 2, '0, '0); tick(); idle();
      checks++;
      if (r_valid !== 1'b1 || r_data !== ref_mem[2]) begin failures++; $display("FAIL wrap got=%b/%h want=1/%h", r_valid, r_data, ref_mem[2]); end
      if (exp_q.size() != 0) exp = exp_q.pop_front();
      tick();
   endtask

   task automatic test_enable();
      enable = 1'b0;
      issue(1'b1, 0, '0, '0);
      checks++; if (gnt !== 1'b0) begin failures++; $display("FAIL enable_gnt got=%b want=0", gnt); end
      tick(); enable = 1'b1; idle();
   endtask

   task automatic test_clear();
      r_ready = 1'b0;
      issue(1'b1, 0, '0, '0); tick();
      issue(1'b1, 1, '0, '0); tick(); idle();
      checks++; if (r_valid !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL clr_pre got=%b/%b want=1/1", r_valid, busy); end
      clear = 1'b1; issue(1'b1, 2, '0, '0);
      checks++; if (gnt !== 1'b0) begin failures++; $display("FAIL clr_gnt got=%b want=0", gnt); end
      tick(); clear = 1'b0; idle();
      checks++; if (r_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL clr_empty got=%b/%b want=0/0", r_valid, busy); end
      checks++; if (rd_cnt !== 0 || wr_cnt !== 0) begin failures++; $display("FAIL clr_cnt got=%0d/%0d want=0/0", rd_cnt, wr_cnt); end
      r_ready = 1'b1;
      issue(1'b1, 9, '0, '0); tick(); idle();
      checks++;
      if (r_valid !== 1'b1 || r_data !== {4{32'h1234_5678}} || rd_cnt !== 1) begin
         failures++; $display("FAIL clr_retain got=%b/%h/%0d want=1/%h/1", r_valid, r_data, rd_cnt, {4{32'h1234_5678}});
      end
      if (exp_q.size() != 0) exp = exp_q.pop_front();
      tick();
   endtask

   task automatic test_back_to_back();
      int resp = 0, issued = 0, cyc = 0, w;
      for (int k = 0; k < 24; k++) begin
         r_ready = ($urandom_range(0, 3) != 0);
         if (r_valid && r_ready) begin
            checks++; exp = exp_q.pop_front(); resp++;
            if (r_data !== exp) begin failures++; $display("FAIL b2b_data%0d got=%h want=%h", resp, r_data, exp); end
         end
         w = $urandom_range(0, 7);
         if (k == 0)      issue(1'b0, 7, {4{32'hCAFE_F00D}}, '1);
         else if (k == 1) issue(1'b1, 7, '0, '0);
         else             issue($urandom_range(0, 1) == 1, w, {$urandom, $urandom, $urandom, $urandom}, BEW'($urandom));
         if (k == 1) begin
            checks++; if (gnt && ref_mem[7] !== {4{32'hCAFE_F00D}}) begin failures++; $display("FAIL b2b_model got=%h", ref_mem[7]); end
         end
         if (gnt && wen) issued++;
         tick();
      end
      idle(); r_ready = 1'b1;
      while (exp_q.size() != 0 && cyc < 40) begin
         if (r_valid) begin
            checks++; exp = exp_q.pop_front(); resp++;
            if (r_data !== exp) begin failures++; $display("FAIL b2b_drain%0d got=%h want=%h", resp, r_data, exp); end
         end
         tick(); cyc++;
      end
      checks++; if (resp != issued || r_valid !== 1'b0) begin failures++; $display("FAIL b2b_count got=%0d/%b want=%0d/0", resp, r_valid, issued); end
   endtask

   task automatic test_reset_mid();
      r_ready = 1'b0;
      issue(1'b1, 0, '0, '0); tick(); idle();
      #2 rst_n = 1'b0; #1;
      checks++; if (r_valid !== 1'b0 || r_data !== '0 || rd_cnt !== 0 || busy !== 1'b0) begin
         failures++; $display("FAIL mid_reset got=%b/%h/%0d/%b want=0/0/0/0", r_valid, r_data, rd_cnt, busy);
      end
      exp_q.delete();
      @(negedge clk); rst_n = 1'b1; r_ready = 1'b1; @(negedge clk);
   endtask

`ifdef RBE_TCDM_RESP_STALL_EN
   task automatic test_stall();
      int grants = 0;
      stall_period = 8'd4; clear = 1'b1; idle(); tick(); clear = 1'b0;
      for (int k = 0; k < 8; k++) begin
         issue(1'b0, 20, '0, '0);
         checks++; if (gnt !== ((k % 4) != 3)) begin failures++; $display("FAIL stall_c%0d got=%b want=%b", k, gnt, (k % 4) != 3); end
         if (gnt) grants++;
         tick();
      end
      idle(); stall_period = 8'd0;
      checks++; if (grants != 6) begin failures++; $display("FAIL stall_count got=%0d want=6", grants); end
   endtask
`endif

   initial begin
      clear = 1'b0; enable = 1'b1; req = 1'b0; wen = 1'b0; add = '0; be = '0;
      wdata = '0; r_ready = 1'b1;
`ifdef RBE_TCDM_RESP_STALL_EN
      stall_period = 8'd0;
`endif
      for (int i = 0; i < NBW; i++) ref_mem[i] = '0;
      @(negedge clk);
      test_reset();
      test_write_read();
      test_byte_enable();
      test_backpressure();
      test_wrap();
      test_enable();
      test_clear();
      test_back_to_back();
      test_reset_mid();
`ifdef RBE_TCDM_RESP_STALL_EN
      test_stall();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
